// File: rtl/subfil_coeffctl_if.sv
// Bus bundle between the coefficient-bank sequencer and its neighbours:
// load request/status, the filter's tap-write port and the sample strobes.
// master = the sequencer, slave = the surrounding environment.
//
// Handshake: i_load is the request (valid), !o_busy is the ready. A load is
// transferred on a clock edge where i_load && !o_busy; i_bank is sampled on
// that same edge. Requests made while o_busy is high are dropped, never held.
interface subfil_coeffctl_if #(
    parameter int CW       = 12,
    parameter int LGNBANKS = 2
);
    logic                i_load;
    logic [LGNBANKS-1:0] i_bank;
    logic                o_busy;
    logic                o_err;
    logic [LGNBANKS-1:0] o_bank;
    logic                o_fil_reset;
    logic                o_tap_wr;
    logic [CW-1:0]       o_tap;
    logic                i_ce;
    logic                o_fil_ce;
    logic                i_fil_ce;
    logic                o_ce;

    modport master (
        input  i_load, i_bank, i_ce, i_fil_ce,
        output o_busy, o_err, o_bank, o_fil_reset, o_tap_wr, o_tap,
               o_fil_ce, o_ce
    );

    modport slave (
        output i_load, i_bank, i_ce, i_fil_ce,
        input  o_busy, o_err, o_bank, o_fil_reset, o_tap_wr, o_tap,
               o_fil_ce, o_ce
    );
endinterface

// File: rtl/subfil_coeffctl.sv
// subfil_coeffctl: coefficient-bank sequencer for the subfildown decimator.
// On a load it pulses the filter reset for one cycle, then streams the NCOEFFS
// taps of the selected bank into the filter's tap-write port, blocking input
// samples while busy. Leaving reset behaves as a load of bank 0.
// Bank contents: word k of bank b is b*NCOEFFS + k + 1 (truncated to CW).
// Optional feature macro: SUBFIL_FLUSH_EN masks the first FLUSH_OUTPUTS filter
// outputs after every reload, until the delay line holds only fresh samples.
module subfil_coeffctl #(
    parameter int CW            = 12,
    parameter int NCOEFFS       = 103,
    parameter int LGNCOEFFS     = $clog2(NCOEFFS),
    parameter int NBANKS        = 4,
    parameter int LGNBANKS      = (NBANKS > 1) ? $clog2(NBANKS) : 1,
    parameter int FLUSH_OUTPUTS = 21
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    subfil_coeffctl_if.master        bus,
    output logic [1:0]               o_state
);
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int                   AW       = LGNBANKS + LGNCOEFFS;
    localparam logic [LGNBANKS:0]    NBANKS_W = (LGNBANKS + 1)'(NBANKS);
    localparam logic [LGNCOEFFS-1:0] LAST_TAP = LGNCOEFFS'(NCOEFFS - 1);

    state_t               state, state_d;
    logic                 fil_reset, fil_reset_d;
    logic [LGNBANKS-1:0]  bank, bank_d;
    logic                 err, err_d;
    logic [LGNCOEFFS-1:0] tap_idx, tap_idx_d;
    logic                 rom_rd;
    logic [AW-1:0]        rom_addr;
    logic [CW-1:0]        rom_q;
    logic                 bad_bank;

    // Fixed coefficient table, addressed {bank, tap}.
    function automatic logic [CW-1:0] rom_word(input logic [AW-1:0] addr);
        int b;
        int k;
        b = int'(addr[AW-1:LGNCOEFFS]);
        k = int'(addr[LGNCOEFFS-1:0]);
        return CW'(b * NCOEFFS + k + 1);
    endfunction

    // Next-state and next-register logic; CLEAR is entered with fil_reset low
    // only straight out of reset, so it spends one extra cycle raising it.
    always_comb begin
        state_d     = state;
        fil_reset_d = 1'b0;
        bank_d      = bank;
        err_d       = 1'b0;
        tap_idx_d   = tap_idx;
        rom_rd      = 1'b0;
        rom_addr    = {bank, tap_idx};
        bad_bank    = ({1'b0, bus.i_bank} >= NBANKS_W);
        case (state)
            CLEAR: begin
                rom_rd    = 1'b1;
                rom_addr  = {bank, {LGNCOEFFS{1'b0}}};
                tap_idx_d = '0;
                if (fil_reset) begin
                    state_d = LOAD;
                end else begin
                    fil_reset_d = 1'b1;
                end
            end
            LOAD: begin
                if (tap_idx == LAST_TAP) begin
                    state_d = RUN;
                end else begin
                    tap_idx_d = tap_idx + 1'b1;
                    rom_rd    = 1'b1;
                    rom_addr  = {bank, tap_idx_d};
                end
            end
            RUN: begin
                if (bus.i_load) begin
                    if (bad_bank) begin
                        err_d = 1'b1;
                    end else begin
                        bank_d      = bus.i_bank;
                        fil_reset_d = 1'b1;
                        state_d     = CLEAR;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= CLEAR;
        end else begin
            state <= state_d;
        end
    end

    // Control registers: filter reset pulse, active bank, error pulse, tap index.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            fil_reset <= 1'b0;
            bank      <= '0;
            err       <= 1'b0;
            tap_idx   <= '0;
        end else begin
            fil_reset <= fil_reset_d;
            bank      <= bank_d;
            err       <= err_d;
            tap_idx   <= tap_idx_d;
        end
    end

    // Registered ROM read: the address leads the tap data by one cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rom_q <= '0;
        end else if (rom_rd) begin
            rom_q <= rom_word(rom_addr);
        end
    end

    assign bus.o_busy      = (state != RUN);
    assign bus.o_err       = err;
    assign bus.o_bank      = bank;
    assign bus.o_fil_reset = fil_reset;
    assign bus.o_tap_wr    = (state == LOAD);
    assign bus.o_tap       = rom_q;
    assign bus.o_fil_ce    = bus.i_ce && (state == RUN);
    assign o_state         = state;

`ifdef SUBFIL_FLUSH_EN
    localparam int FW = $clog2(FLUSH_OUTPUTS + 1);
    logic [FW-1:0] flush;

    // Count down filter outputs after each reload; reload wins over decrement.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            flush <= FW'(FLUSH_OUTPUTS);
        end else if ((state == LOAD) && (state_d == RUN)) begin
            flush <= FW'(FLUSH_OUTPUTS);
        end else if (bus.i_fil_ce && (flush != '0)) begin
            flush <= flush - 1'b1;
        end
    end

    assign bus.o_ce = bus.i_fil_ce && (state == RUN) && (flush == '0);
`else
    assign bus.o_ce = bus.i_fil_ce && (state == RUN);
`endif
endmodule

// File: tb/tb_subfil_coeffctl.sv
// Bench for subfil_coeffctl: a behavioural model (cycles since load acceptance,
// bank, flush pulse count) is checked against the DUT every cycle, plus
// hand-computed expectations for the documented scenarios.
module tb_subfil_coeffctl;
    localparam int CW        = 12;
    localparam int NCOEFFS   = 103;
    localparam int NBANKS    = 4;
    localparam int LGNBANKS  = 3;
    localparam int FLUSH     = 21;
    localparam int BUSY_SPAN = NCOEFFS + 1;
`ifdef SUBFIL_FLUSH_EN
    localparam int EXP_CE = 9;
`else
    localparam int EXP_CE = 30;
`endif

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         vectors;
    int         miscompares;

    subfil_coeffctl_if #(.CW(CW), .LGNBANKS(LGNBANKS)) bus ();

    subfil_coeffctl #(
        .CW(CW), .NCOEFFS(NCOEFFS), .NBANKS(NBANKS), .LGNBANKS(LGNBANKS),
        .FLUSH_OUTPUTS(FLUSH)
    ) dut (
        .i_clk(clk), .i_reset(rst), .bus(bus), .o_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rom_val(input int b, input int k);
        return (b * NCOEFFS + k + 1) % (1 << CW);
    endfunction

    // ---------------- behavioural model ----------------
    // since = cycles since the accepted load (-1: pending after reset);
    // since >= BUSY_SPAN means running.
    int         since;
    int         m_bank;
    int         m_err;
    int         m_pulses;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            since    = -1;
            m_bank   = 0;
            m_err    = 0;
            m_pulses = 0;
        end else begin
            m_err = 0;
            if (since < 0) begin
                since = 0;
            end else if (since < BUSY_SPAN) begin
                since++;
                if (since == BUSY_SPAN) m_pulses = 0;
            end else begin
                if (bus.i_fil_ce) m_pulses++;
                if (bus.i_load) begin
                    if (int'(bus.i_bank) >= NBANKS) begin
                        m_err = 1;
                    end else begin
                        m_bank = int'(bus.i_bank);
                        since  = 0;
                    end
                end
            end
        end
    end

    // ---------------- compare process ----------------
    int run;
    int exp_ce;
    always @(negedge clk) begin
        if (rst) begin
            check("rst_busy", int'(bus.o_busy), 1);
            check("rst_fil_reset", int'(bus.o_fil_reset), 0);
            check("rst_tap_wr", int'(bus.o_tap_wr), 0);
            check("rst_tap", int'(bus.o_tap), 0);
            check("rst_bank", int'(bus.o_bank), 0);
            check("rst_err", int'(bus.o_err), 0);
        end else begin
            run    = (since >= BUSY_SPAN) ? 1 : 0;
            exp_ce = (bus.i_fil_ce && run != 0) ? 1 : 0;
`ifdef SUBFIL_FLUSH_EN
            if (m_pulses < FLUSH) exp_ce = 0;
`endif
            check("busy", int'(bus.o_busy), 1 - run);
            check("fil_reset", int'(bus.o_fil_reset), (since == 0) ? 1 : 0);
            check("tap_wr", int'(bus.o_tap_wr), (since >= 1 && since <= NCOEFFS) ? 1 : 0);
            if (since >= 1 && since <= NCOEFFS)
                check("tap", int'(bus.o_tap), rom_val(m_bank, since - 1));
            check("bank", int'(bus.o_bank), m_bank);
            check("err", int'(bus.o_err), m_err);
            check("fil_ce", int'(bus.o_fil_ce), (bus.i_ce && run != 0) ? 1 : 0);
            check("ce", int'(bus.o_ce), exp_ce);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input int b);
        bus.i_load = 1'b1;
        bus.i_bank = LGNBANKS'(b);
        tick();
        bus.i_load = 1'b0;
    endtask

    // Observe a busy period from the next negedge (index 0) until o_busy falls.
    // A load request for bank 3 is offered at index poke_at (if >= 0).
    task automatic watch_seq(input int poke_at, output int fr_at, output int first_wr,
                             output int last_wr, output int fall_at, output int wr_n,
                             output int first_tap, output int last_tap);
        fr_at = -1; first_wr = -1; last_wr = -1; fall_at = -1;
        wr_n = 0; first_tap = -1; last_tap = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (i == poke_at) begin
                bus.i_load = 1'b1;
                bus.i_bank = 3'd3;
            end else if (i == poke_at + 1) begin
                bus.i_load = 1'b0;
            end
            if (!bus.o_busy) begin
                fall_at = i;
                break;
            end
            if (bus.o_fil_reset && fr_at < 0) fr_at = i;
            if (bus.o_tap_wr) begin
                if (first_wr < 0) begin
                    first_wr  = i;
                    first_tap = int'(bus.o_tap);
                end
                last_wr  = i;
                last_tap = int'(bus.o_tap);
                wr_n++;
            end
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // ---------------- main sequence ----------------
    int fr_at, first_wr, last_wr, fall_at, wr_n, first_tap, last_tap, ce_n;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.i_load  = 1'b0;
        bus.i_bank  = '0;
        bus.i_ce    = 1'b1;
        bus.i_fil_ce = 1'b0;
        repeat (3) tick();

        // Reset release: bank 0 streams 1..103, i_ce held high throughout.
        rst = 1'b0;
        watch_seq(-1, fr_at, first_wr, last_wr, fall_at, wr_n, first_tap, last_tap);
        check("boot_fr_at", fr_at, 1);
        check("boot_first_wr", first_wr, 2);
        check("boot_last_wr", last_wr, 104);
        check("boot_fall", fall_at, 105);
        check("boot_first_tap", first_tap, 1);
        check("boot_last_tap", last_tap, 103);
        check("boot_writes", wr_n, 103);
        check("boot_fil_ce_run", int'(bus.o_fil_ce), 1);
        tick();
        bus.i_ce = 1'b0;

        // Load bank 2 from RUN.
        start_load(2);
        watch_seq(-1, fr_at, first_wr, last_wr, fall_at, wr_n, first_tap, last_tap);
        check("b2_fr_at", fr_at, 0);
        check("b2_first_wr", first_wr, 1);
        check("b2_busy_span", fall_at, 104);
        check("b2_writes", wr_n, 103);
        check("b2_first_tap", first_tap, 207);
        check("b2_last_tap", last_tap, 309);
        check("b2_bank", int'(bus.o_bank), 2);
        tick();

        // Invalid bank: one-cycle error, nothing else moves.
        start_load(5);
        @(negedge clk);
        check("inv_err", int'(bus.o_err), 1);
        check("inv_bank", int'(bus.o_bank), 2);
        check("inv_busy", int'(bus.o_busy), 0);
        check("inv_tap_wr", int'(bus.o_tap_wr), 0);
        tick();
        @(negedge clk);
        check("inv_err_drop", int'(bus.o_err), 0);
        tick();

        // Load bank 1; a request at LOAD cycle 50 must be ignored.
        start_load(1);
        watch_seq(50, fr_at, first_wr, last_wr, fall_at, wr_n, first_tap, last_tap);
        check("poke_writes", wr_n, 103);
        check("poke_span", fall_at, 104);
        check("poke_first_tap", first_tap, 104);
        check("poke_bank", int'(bus.o_bank), 1);
        tick();

        // 30 filter output strobes after the load.
        ce_n = 0;
        for (int p = 0; p < 30; p++) begin
            bus.i_fil_ce = 1'b1;
            @(negedge clk);
            if (bus.o_ce) ce_n++;
            tick();
            bus.i_fil_ce = 1'b0;
            tick();
        end
        check("flush_ce_count", ce_n, EXP_CE);

        // Reset in the middle of a bank-3 load.
        start_load(3);
        repeat (40) tick();
        rst = 1'b1;
        #1;
        check("arst_busy", int'(bus.o_busy), 1);
        check("arst_tap_wr", int'(bus.o_tap_wr), 0);
        check("arst_bank", int'(bus.o_bank), 0);
        check("arst_fil_reset", int'(bus.o_fil_reset), 0);
        repeat (2) tick();
        rst = 1'b0;
        watch_seq(-1, fr_at, first_wr, last_wr, fall_at, wr_n, first_tap, last_tap);
        check("arst_fr_at", fr_at, 1);
        check("arst_fall", fall_at, 105);
        check("arst_writes", wr_n, 103);
        check("arst_first_tap", first_tap, 1);
        check("arst_last_tap", last_tap, 103);
        tick();

        // Randomised traffic checked by the compare process.
        for (int c = 0; c < 3000; c++) begin
            bus.i_ce     = 1'($urandom_range(0, 1));
            bus.i_fil_ce = 1'($urandom_range(0, 1));
            bus.i_load   = ($urandom_range(0, 15) == 0);
            bus.i_bank   = LGNBANKS'($urandom_range(0, 7));
            if (c == 1500) rst = 1'b1;
            if (c == 1503) rst = 1'b0;
            tick();
        end
        bus.i_load   = 1'b0;
        bus.i_ce     = 1'b0;
        bus.i_fil_ce = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
